// File: rtl/decode_grant_tracker.sv
// Grant tracker behind the master-side address decoder. It holds the slave grant while
// acknowledgements are outstanding. A switch to another slave waits until every
// outstanding return has arrived, so returns stay in order. Requests to unmapped
// addresses are answered with a single-cycle bus error.
module decode_grant_tracker #(
    parameter int unsigned NS         = 8,
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 38,
    parameter int unsigned LGMAXBURST = 4
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_cyc,
    input  logic              i_valid,
    output logic              o_stall,
    input  logic [NS:0]       i_decode,
    input  logic [AW-1:0]     i_addr,
    input  logic [DW-1:0]     i_data,
    output logic              o_valid,
    input  logic              i_stall,
    output logic [NS:0]       o_grant,
    output logic [AW-1:0]     o_addr,
    output logic [DW-1:0]     o_data,
    input  logic              i_ack,
    input  logic              i_err,
    output logic              o_ack,
    output logic              o_err,
    output logic              o_busy
);

    localparam int unsigned MaxOut = (1 << LGMAXBURST) - 1;
    localparam logic [LGMAXBURST:0] CntMax = MaxOut[LGMAXBURST:0];

    logic [NS:0]         grant_q, grant_d;
    logic [LGMAXBURST:0] cnt_q, cnt_d;
    logic                berr_pend_q, berr_pend_d;

    logic cnt_zero, match, room, unmapped;
    logic fwd, acc_slave, acc_berr, inc, dec;

    // Request path decisions; all combinational so decoder-to-slave latency is zero.
    always_comb begin
        cnt_zero  = (cnt_q == '0);
        match     = cnt_zero || (i_decode == grant_q);
        room      = (cnt_q < CntMax);
        unmapped  = i_decode[NS];
        fwd       = i_cyc && i_valid && !unmapped && match && room && !berr_pend_q;
        acc_slave = fwd && !i_stall;
        acc_berr  = i_cyc && i_valid && unmapped && cnt_zero && !berr_pend_q;
        inc       = acc_slave;
        dec       = i_cyc && (i_ack || i_err) && !cnt_zero;
    end

    // Outputs to slave and master; a pending bus error stalls the decoder for its cycle.
    always_comb begin
        o_valid = fwd;
        o_stall = i_cyc && (berr_pend_q ||
                  (i_valid && (unmapped ? !cnt_zero : (!match || !room || i_stall))));
        o_ack   = i_cyc && i_ack && !cnt_zero;
        o_err   = i_cyc && ((i_err && !cnt_zero) || berr_pend_q);
        o_grant = grant_q;
        o_addr  = i_addr;
        o_data  = i_data;
        o_busy  = !cnt_zero || berr_pend_q;
    end

    // Next-state: grant only moves while idle; a dropped cycle discards all tracking.
    always_comb begin
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        berr_pend_d = 1'b0;
        if (!i_cyc) begin
            grant_d = '0;
            cnt_d   = '0;
        end else begin
            if (cnt_zero) begin
                grant_d = (acc_slave || acc_berr) ? i_decode : '0;
            end
            unique case ({inc, dec})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
            berr_pend_d = acc_berr;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            grant_q     <= '0;
            cnt_q       <= '0;
            berr_pend_q <= 1'b0;
        end else begin
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            berr_pend_q <= berr_pend_d;
        end
    end

endmodule

// File: tb/tb_decode_grant_tracker.sv
// Bench for decode_grant_tracker: directed table, corner sequences, random vs model.
module tb_decode_grant_tracker;

    localparam int NS = 8;
    localparam int AW = 32;
    localparam int DW = 38;
    localparam int MAXOUT = 15;

    logic          i_clk = 1'b0;
    logic          i_reset_n, i_cyc, i_valid, i_stall, i_ack, i_err;
    logic [NS:0]   i_decode;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_data;
    logic          o_stall, o_valid, o_ack, o_err, o_busy;
    logic [NS:0]   o_grant;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_data;

    int n_vec = 0;
    int n_bad = 0;

    // Reference state: outstanding count, granted slave index (-1 none), bus error pending.
    int m_cnt   = 0;
    int m_slave = -1;
    bit m_berr  = 0;

    always #5 i_clk = ~i_clk;

    decode_grant_tracker #(.NS(NS), .AW(AW), .DW(DW), .LGMAXBURST(4)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_cyc(i_cyc), .i_valid(i_valid),
        .o_stall(o_stall), .i_decode(i_decode), .i_addr(i_addr), .i_data(i_data),
        .o_valid(o_valid), .i_stall(i_stall), .o_grant(o_grant), .o_addr(o_addr),
        .o_data(o_data), .i_ack(i_ack), .i_err(i_err), .o_ack(o_ack), .o_err(o_err),
        .o_busy(o_busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [NS:0] m_grant_vec();
        return (m_slave < 0) ? '0 : (NS+1)'(1 << m_slave);
    endfunction

    function automatic int onehot_idx(input logic [NS:0] v);
        for (int k = 0; k <= NS; k++) if (v[k]) return k;
        return -1;
    endfunction

    // Compare every output against the model for the inputs now applied.
    task automatic check_model();
        bit unm, match, ev, es;
        unm   = i_decode[NS];
        match = (m_cnt == 0) || (m_slave >= 0 && onehot_idx(i_decode) == m_slave);
        ev = i_cyc && i_valid && !unm && match && (m_cnt < MAXOUT) && !m_berr;
        if (unm) es = i_cyc && (m_berr || (i_valid && m_cnt != 0));
        else es = i_cyc && (m_berr || (i_valid && (!match || m_cnt >= MAXOUT || i_stall)));
        chk("valid", 64'(o_valid), 64'(ev));
        chk("stall", 64'(o_stall), 64'(es));
        chk("ack", 64'(o_ack), 64'(i_cyc && i_ack && m_cnt != 0));
        chk("err", 64'(o_err), 64'(i_cyc && ((i_err && m_cnt != 0) || m_berr)));
        chk("grant", 64'(o_grant), 64'(m_grant_vec()));
        chk("busy", 64'(o_busy), 64'(m_cnt != 0 || m_berr));
        chk("addr", 64'(o_addr), 64'(i_addr));
        chk("data", 64'(o_data), 64'(i_data));
    endtask

    task automatic drive(input bit cyc, input bit valid, input logic [NS:0] dec,
                         input bit stall, input bit ack, input bit err, input bit do_chk);
        i_cyc = cyc; i_valid = valid; i_decode = valid ? dec : '0;
        i_stall = stall; i_ack = ack; i_err = err;
        i_addr = $urandom; i_data = {$urandom, $urandom} & {DW{1'b1}};
        #1;
        if (do_chk) check_model();
    endtask

    // Clock edge: advance the model by the rules, then return to the negative edge.
    task automatic tick();
        bit unm, match, acc_s, acc_u, dn;
        unm   = i_decode[NS];
        match = (m_cnt == 0) || (m_slave >= 0 && onehot_idx(i_decode) == m_slave);
        acc_s = i_cyc && i_valid && !unm && match && (m_cnt < MAXOUT) && !m_berr && !i_stall;
        acc_u = i_cyc && i_valid && unm && m_cnt == 0 && !m_berr;
        dn    = (i_ack || i_err) && m_cnt != 0;
        @(posedge i_clk);
        if (!i_reset_n || !i_cyc) begin
            m_cnt = 0; m_slave = -1; m_berr = 0;
        end else begin
            if (m_cnt == 0) m_slave = (acc_s || acc_u) ? onehot_idx(i_decode) : -1;
            m_cnt  = m_cnt + int'(acc_s) - int'(dn);
            m_berr = acc_u;
        end
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        i_reset_n = 1'b0;
        drive(1, 0, '0, 0, 0, 0, 0);
        tick();
        i_reset_n = 1'b1;
    endtask

    typedef struct {
        bit cyc, valid; logic [NS:0] dec; bit stall, ack, err;
        bit e_valid, e_stall, e_ack, e_err, e_busy; logic [NS:0] e_grant;
    } vec_t;

    vec_t tbl[10];

    initial begin
        // cyc valid dec stall ack err | valid stall ack err busy grant
        tbl[0] = '{1, 1, 9'h004, 0, 0, 0, 1, 0, 0, 0, 0, 9'h000};
        tbl[1] = '{1, 1, 9'h004, 0, 1, 0, 1, 0, 1, 0, 1, 9'h004};
        tbl[2] = '{1, 1, 9'h004, 0, 1, 0, 1, 0, 1, 0, 1, 9'h004};
        tbl[3] = '{1, 0, 9'h000, 0, 1, 0, 0, 0, 1, 0, 1, 9'h004};
        tbl[4] = '{1, 0, 9'h000, 0, 0, 0, 0, 0, 0, 0, 0, 9'h004};
        tbl[5] = '{1, 1, 9'h100, 0, 0, 0, 0, 0, 0, 0, 0, 9'h000};
        tbl[6] = '{1, 0, 9'h000, 0, 0, 0, 0, 1, 0, 1, 1, 9'h100};
        tbl[7] = '{1, 0, 9'h000, 0, 1, 1, 0, 0, 0, 0, 0, 9'h000};
        tbl[8] = '{1, 1, 9'h010, 1, 0, 0, 1, 1, 0, 0, 0, 9'h000};
        tbl[9] = '{1, 0, 9'h000, 0, 1, 0, 0, 0, 0, 0, 0, 9'h000};

        i_reset_n = 1'b0;
        drive(0, 0, '0, 0, 0, 0, 0);
        @(negedge i_clk);
        tick();
        drive(1, 0, '0, 0, 0, 0, 0);
        chk("reset_grant", 64'(o_grant), 64'h0);
        chk("reset_busy", 64'(o_busy), 64'h0);
        i_reset_n = 1'b1;
        tick();

        // Directed table: burst to slave 2, unmapped error, spurious returns, slave stall.
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].cyc, tbl[i].valid, tbl[i].dec, tbl[i].stall, tbl[i].ack,
                  tbl[i].err, 0);
            chk($sformatf("tbl%0d_valid", i), 64'(o_valid), 64'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_stall", i), 64'(o_stall), 64'(tbl[i].e_stall));
            chk($sformatf("tbl%0d_ack", i), 64'(o_ack), 64'(tbl[i].e_ack));
            chk($sformatf("tbl%0d_err", i), 64'(o_err), 64'(tbl[i].e_err));
            chk($sformatf("tbl%0d_busy", i), 64'(o_busy), 64'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_grant", i), 64'(o_grant), 64'(tbl[i].e_grant));
            tick();
        end

        // Slave switch waits for the previous slave to drain.
        do_reset();
        for (int i = 0; i < 3; i++) begin drive(1, 1, 9'h001, 0, 0, 0, 1); tick(); end
        drive(1, 1, 9'h002, 0, 0, 0, 1);
        chk("switch_stall", 64'(o_stall), 64'h1);
        chk("switch_hold", 64'(o_valid), 64'h0);
        tick();
        for (int i = 0; i < 3; i++) begin drive(1, 1, 9'h002, 0, 1, 0, 1); tick(); end
        drive(1, 1, 9'h002, 0, 0, 0, 1);
        chk("switch_fwd", 64'(o_valid), 64'h1);
        tick();
        drive(1, 0, '0, 0, 1, 0, 1);
        chk("switch_grant", 64'(o_grant), 64'h002);
        tick();

        // Fill the outstanding counter to its limit.
        do_reset();
        for (int i = 0; i < MAXOUT; i++) begin drive(1, 1, 9'h008, 0, 0, 0, 1); tick(); end
        drive(1, 1, 9'h008, 0, 0, 0, 1);
        chk("full_stall", 64'(o_stall), 64'h1);
        chk("full_valid", 64'(o_valid), 64'h0);
        tick();
        drive(1, 1, 9'h008, 0, 1, 0, 1);
        chk("full_ack", 64'(o_ack), 64'h1);
        tick();
        drive(1, 1, 9'h008, 0, 0, 0, 1);
        chk("full_refill", 64'(o_valid), 64'h1);
        tick();
        drive(1, 1, 9'h008, 0, 0, 0, 1);
        chk("full_again", 64'(o_stall), 64'h1);
        tick();

        // Abort mid-burst: acks after the dropped cycle are spurious.
        do_reset();
        for (int i = 0; i < 2; i++) begin drive(1, 1, 9'h020, 0, 0, 0, 1); tick(); end
        drive(0, 0, '0, 0, 0, 0, 1);
        tick();
        drive(1, 0, '0, 0, 1, 0, 1);
        chk("abort_ack", 64'(o_ack), 64'h0);
        chk("abort_grant", 64'(o_grant), 64'h0);
        chk("abort_busy", 64'(o_busy), 64'h0);
        tick();

        // Reset mid-burst clears everything; next request goes straight through.
        for (int i = 0; i < 4; i++) begin drive(1, 1, 9'h004, 0, 0, 0, 1); tick(); end
        do_reset();
        drive(1, 0, '0, 0, 0, 0, 1);
        chk("rst_busy", 64'(o_busy), 64'h0);
        chk("rst_grant", 64'(o_grant), 64'h0);
        tick();
        drive(1, 1, 9'h040, 0, 0, 0, 1);
        chk("rst_fwd", 64'(o_valid), 64'h1);
        chk("rst_nostall", 64'(o_stall), 64'h0);
        tick();

        // Random traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            bit cyc, valid;
            logic [NS:0] dec;
            int r;
            if ($urandom_range(0, 199) == 0) do_reset();
            cyc   = ($urandom_range(0, 24) != 0);
            valid = ($urandom_range(0, 2) != 0);
            r     = $urandom_range(0, 11);
            dec   = (r == 11) ? (NS+1)'(1 << NS) : (NS+1)'(1 << (r % 3));
            drive(cyc, valid, dec, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, 1);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
